// File: rtl/register_write_arbiter.sv
// register_write_arbiter: shares the load/in port of one DATA_SIZE-wide Register
// between NUM_REQ valid/ready requesters. Round-robin arbitration by default;
// define REG_ARB_FIXED_PRIO_EN for lowest-index-wins priority. An owner may
// hold ownership with req_lock for up to LOCK_MAX back-to-back transfers.
module register_write_arbiter #(
   parameter int DATA_SIZE = 16,
   parameter int NUM_REQ   = 4,
   parameter int LOCK_MAX  = 8
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ-1:0]             req_lock,
   input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic [DATA_SIZE-1:0]           reg_in,
   output logic                           reg_load,
   output logic [$clog2(NUM_REQ)-1:0]     grant_id,
   output logic                           busy
);

   localparam int          ID_W = $clog2(NUM_REQ);
   localparam int unsigned NR   = NUM_REQ;

   typedef enum logic [1:0] {IDLE, GRANT, LOCK} state_t;

   state_t          state;
   logic [ID_W-1:0] owner;
   logic [7:0]      burst_cnt;
   logic [8:0]      burst_next;
   logic [ID_W-1:0] winner;
   logic            found;
   logic            xfer;
`ifndef REG_ARB_FIXED_PRIO_EN
   logic [ID_W-1:0] last_ptr;
   int unsigned     idx;
`endif

   assign busy       = (state != IDLE);
   assign grant_id   = owner;
   assign burst_next = {1'b0, burst_cnt} + 9'd1;
   assign xfer       = !reset && (state != IDLE) && req_valid[owner];

   // Winner selection for the next arbitration in IDLE
   always_comb begin
      winner = '0;
      found  = 1'b0;
`ifdef REG_ARB_FIXED_PRIO_EN
      for (int unsigned i = 0; i < NR; i++) begin
         if (!found && req_valid[i]) begin
            winner = ID_W'(i);
            found  = 1'b1;
         end
      end
`else
      idx = 0;
      // scan starts just after the last owner so it gets lowest priority
      for (int unsigned k = 1; k <= NR; k++) begin
         idx = (32'(last_ptr) + k) % NR;
         if (!found && req_valid[idx]) begin
            winner = ID_W'(idx);
            found  = 1'b1;
         end
      end
`endif
   end

   // Only the current owner may see ready; nothing is accepted during reset
   always_comb begin
      req_ready = '0;
      if (!reset && (state != IDLE))
         req_ready[owner] = req_valid[owner];
   end

   // Arbitration FSM with registered Register-side outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         reg_in    <= '0;
         reg_load  <= 1'b0;
         owner     <= '0;
         burst_cnt <= '0;
`ifndef REG_ARB_FIXED_PRIO_EN
         last_ptr  <= ID_W'(NUM_REQ - 1);
`endif
      end else begin
         reg_load <= 1'b0;
         case (state)
            IDLE: begin
               if (|req_valid) begin
                  owner     <= winner;
                  burst_cnt <= '0;
                  state     <= GRANT;
               end
            end
            GRANT, LOCK: begin
               if (xfer) begin
                  reg_in    <= req_data[32'(owner)*DATA_SIZE +: DATA_SIZE];
                  reg_load  <= 1'b1;
                  burst_cnt <= burst_next[7:0];
`ifndef REG_ARB_FIXED_PRIO_EN
                  last_ptr  <= owner;
`endif
                  if (req_lock[owner] && (burst_next < 9'(LOCK_MAX)))
                     state <= LOCK;
                  else
                     state <= IDLE;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_register_write_arbiter.sv
// tb_register_write_arbiter: directed vectors with hand-computed expectations
// for reset, single request, round-robin, lock burst, withdraw and reset mid-burst.
module tb_register_write_arbiter;

   localparam int DW = 16;
   localparam int NR = 4;

   logic             clock = 1'b0;
   logic             reset;
   logic [NR-1:0]    req_valid;
   logic [NR-1:0]    req_lock;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0]    req_ready;
   logic [DW-1:0]    reg_in;
   logic             reg_load;
   logic [1:0]       grant_id;
   logic             busy;

   int checks   = 0;
   int failures = 0;

   register_write_arbiter #(.DATA_SIZE(DW), .NUM_REQ(NR), .LOCK_MAX(8)) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_lock  (req_lock),
      .req_data  (req_data),
      .req_ready (req_ready),
      .reg_in    (reg_in),
      .reg_load  (reg_load),
      .grant_id  (grant_id),
      .busy      (busy)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // advance one rising edge, then settle away from it
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_data(input int i, input logic [DW-1:0] v);
      req_data[i*DW +: DW] = v;
   endtask

   int exp_id;

   initial begin
      reset     = 1'b1;
      req_valid = '0;
      req_lock  = '0;
      req_data  = '0;
      tick();
      req_valid = 4'b1111;
      #1;
      check("reset_ready", 32'(req_ready), 32'h0);
      tick();
      check("reset_load", 32'(reg_load), 32'h0);
      check("reset_in", 32'(reg_in), 32'h0);
      check("reset_gid", 32'(grant_id), 32'h0);
      check("reset_busy", 32'(busy), 32'h0);
      req_valid = '0;
      reset     = 1'b0;
      tick();

      // single request from requester 0
      req_valid = 4'b0001;
      set_data(0, 16'h1234);
      #1;
      check("single_ready_n", 32'(req_ready), 32'h0);
      tick();
      check("single_ready_n1", 32'(req_ready), 32'h1);
      check("single_busy_n1", 32'(busy), 32'h1);
      check("single_load_n1", 32'(reg_load), 32'h0);
      tick();
      req_valid = '0;
      check("single_load_n2", 32'(reg_load), 32'h1);
      check("single_in_n2", 32'(reg_in), 32'h1234);
      tick();
      check("single_load_n3", 32'(reg_load), 32'h0);
      check("single_in_hold", 32'(reg_in), 32'h1234);
      check("single_busy_n3", 32'(busy), 32'h0);
      check("single_gid", 32'(grant_id), 32'h0);

      // round-robin with all requesters valid, starting from reset pointer
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < NR; i++) set_data(i, 16'hA000 + 16'(i));
      req_valid = 4'b1111;
      for (int k = 0; k < 5; k++) begin
`ifdef REG_ARB_FIXED_PRIO_EN
         exp_id = 0;
`else
         exp_id = k % NR;
`endif
         tick();
         check("rr_gid", 32'(grant_id), 32'(exp_id));
         check("rr_ready", 32'(req_ready), 32'(1 << exp_id));
         tick();
         check("rr_load", 32'(reg_load), 32'h1);
         check("rr_in", 32'(reg_in), 32'hA000 + 32'(exp_id));
         check("rr_busy", 32'(busy), 32'h0);
      end
      req_valid = '0;
      reset = 1'b1;
      tick();
      reset = 1'b0;

      // lock burst by requester 2, requester 1 arrives while busy
      req_valid = 4'b0100;
      req_lock  = 4'b0100;
      set_data(2, 16'd5);
      set_data(1, 16'h00B1);
      tick();
      check("lock_gid", 32'(grant_id), 32'h2);
      req_valid = 4'b0110;
      for (int i = 0; i < 8; i++) begin
         #1;
         check("lock_ready", 32'(req_ready), 32'h4);
         tick();
         check("lock_load", 32'(reg_load), 32'h1);
         check("lock_in", 32'(reg_in), 32'(5 + i));
         check("lock_busy", 32'(busy), (i < 7) ? 32'h1 : 32'h0);
         set_data(2, 16'(6 + i));
         if (i == 7) begin
            req_valid = 4'b0010;
            req_lock  = '0;
         end
      end
      tick();
      check("lock_next_gid", 32'(grant_id), 32'h1);
      check("lock_next_ready", 32'(req_ready), 32'h2);
      check("lock_next_noload", 32'(reg_load), 32'h0);
      tick();
      req_valid = '0;
      check("lock_next_load", 32'(reg_load), 32'h1);
      check("lock_next_in", 32'(reg_in), 32'h00B1);

      // requester 3 withdraws in GRANT
      req_valid = 4'b1000;
      tick();
      check("wd_gid", 32'(grant_id), 32'h3);
      req_valid = '0;
      #1;
      check("wd_ready", 32'(req_ready), 32'h0);
      tick();
      check("wd_load", 32'(reg_load), 32'h0);
      check("wd_busy", 32'(busy), 32'h0);
      check("wd_in_hold", 32'(reg_in), 32'h00B1);
      req_valid = 4'b1111;
      tick();
`ifdef REG_ARB_FIXED_PRIO_EN
      check("wd_ptr_gid", 32'(grant_id), 32'h0);
`else
      check("wd_ptr_gid", 32'(grant_id), 32'h2);
`endif
      req_valid = '0;
      tick();
      check("wd2_load", 32'(reg_load), 32'h0);

      // reset during the third transfer of a burst
      req_valid = 4'b0001;
      req_lock  = 4'b0001;
      set_data(0, 16'd100);
      tick();
      tick();
      set_data(0, 16'd101);
      tick();
      set_data(0, 16'd102);
      check("mid_load2", 32'(reg_load), 32'h1);
      check("mid_in2", 32'(reg_in), 32'd101);
      check("mid_busy2", 32'(busy), 32'h1);
      reset = 1'b1;
      #1;
      check("mid_ready_rst", 32'(req_ready), 32'h0);
      tick();
      check("mid_load", 32'(reg_load), 32'h0);
      check("mid_in", 32'(reg_in), 32'h0);
      check("mid_busy", 32'(busy), 32'h0);
      check("mid_gid", 32'(grant_id), 32'h0);
      reset     = 1'b0;
      req_valid = '0;
      req_lock  = '0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
